// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle for uart_tx_arbiter.
// The arbiter binds to the slave modport; the environment binds to master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      owner_id;
  logic               busy;
  logic               timeout_err;
  logic [7:0]         data_send;
  logic               ena_tx;
  logic               tx_done;

  modport slave (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, grant, owner_id, busy, timeout_err, data_send, ena_tx
  );

  modport master (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, grant, owner_id, busy, timeout_err, data_send, ena_tx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between
// N_REQ byte streams, with optional owner tag byte and idle watchdog.
module uart_tx_arbiter #(
  parameter int         N_REQ        = 4,
  parameter bit         TAG_EN       = 1'b1,
  parameter logic [7:0] TAG_BASE     = 8'hA0,
  parameter int         IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              nrst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] CNT_TRIP = CW'(IDLE_TIMEOUT - 1);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TAG   = 2'd1,
    S_FETCH = 2'd2,
    S_SEND  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               ena_tx_q, ena_tx_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         data_send_q, data_send_d;

  logic               any_req_s;
  logic [IW-1:0]      win_s;
  logic [IW:0]        idx_s;
  logic               xfer_s;
  logic               timeout_s;
  logic [IW-1:0]      nxt_ptr_s;
  logic [7:0]         lane_data_s;

  // Round-robin search: first valid index at or after ptr, with wrap.
  always_comb begin
    any_req_s = 1'b0;
    win_s     = '0;
    idx_s     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = {1'b0, ptr_q} + (IW+1)'(i);
      idx_s = (idx_s >= N_EXT) ? (idx_s - N_EXT) : idx_s;
      if (!any_req_s && bus.req_valid[idx_s[IW-1:0]]) begin
        any_req_s = 1'b1;
        win_s     = idx_s[IW-1:0];
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  assign xfer_s      = (state_q == S_FETCH) && bus.req_valid[owner_q];
  assign lane_data_s = bus.req_data[{owner_q, 3'b000} +: 8];
  assign nxt_ptr_s   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign timeout_s   = (IDLE_TIMEOUT != 0) && (state_q == S_FETCH) && !xfer_s
                       && (cnt_q == CNT_TRIP);

  // Only the owner's lane can ever see ready, and only while fetching.
  assign bus.req_ready = (state_q == S_FETCH) ? (bus.req_valid & grant_q) : '0;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = any_req_s ? (TAG_EN ? S_TAG : S_FETCH) : S_IDLE;
      S_TAG:   state_d = bus.tx_done ? S_FETCH : S_TAG;
      S_FETCH: begin
        if (xfer_s) begin
          state_d = S_SEND;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_SEND: begin
        if (bus.tx_done) begin
          state_d = last_q ? S_IDLE : S_FETCH;
        end else begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything visible is registered below.
  always_comb begin
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    data_send_d = data_send_q;
    last_d      = last_q;
    cnt_d       = '0;
    timeout_d   = 1'b0;
    ena_tx_d    = (state_d == S_TAG) || (state_d == S_SEND);
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
          owner_d     = win_s;
          data_send_d = TAG_EN ? (TAG_BASE | 8'(win_s)) : data_send_q;
        end else begin
          grant_d = '0;
        end
      end
      S_FETCH: begin
        if (xfer_s) begin
          data_send_d = lane_data_s;
          last_d      = bus.req_last[owner_q];
        end else if (timeout_s) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          owner_d   = '0;
          ptr_d     = nxt_ptr_s;
        end else begin
          cnt_d = (cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
        end
      end
      S_SEND: begin
        if (bus.tx_done && last_q) begin
          grant_d = '0;
          owner_d = '0;
          ptr_d   = nxt_ptr_s;
        end else begin
          grant_d = grant_q;
        end
      end
      S_TAG:   grant_d = grant_q;
      default: grant_d = grant_q;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      data_send_q <= 8'h00;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      ena_tx_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      data_send_q <= data_send_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      ena_tx_q    <= ena_tx_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner_id    = owner_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_q;
  assign bus.data_send   = data_send_q;
  assign bus.ena_tx      = ena_tx_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected line bytes, UART models pop and
// compare on every completed frame. dut_a is tagged, dut_b untagged.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 3;

  typedef struct {
    logic [N-1:0] g;
    logic [7:0]   b;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  uart_tx_arbiter_if #(.N_REQ(N)) bus_a ();
  uart_tx_arbiter_if #(.N_REQ(N)) bus_b ();

  uart_tx_arbiter #(.N_REQ(N), .TAG_EN(1'b1), .TAG_BASE(8'hA0), .IDLE_TIMEOUT(16)) dut_a (
    .clk(clk), .nrst(nrst), .bus(bus_a)
  );
  uart_tx_arbiter #(.N_REQ(N), .TAG_EN(1'b0), .TAG_BASE(8'hA0), .IDLE_TIMEOUT(1024)) dut_b (
    .clk(clk), .nrst(nrst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane buffers for dut_a requesters and dut_b requester 0.
  logic [8:0] lbuf [N][32];
  int         lhead [N];
  int         ltail [N];
  int         xcnt [N];
  int         bad_ready = 0;
  exp_t       exp_a [$];
  logic [8:0] lbuf_b [16];
  int         lhead_b = 0;
  int         ltail_b = 0;
  logic [7:0] exp_b [$];

  task automatic push_pkt(input int lane, input int n, input bit lastf,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bytes [3];
    exp_t e;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    e.g = 4'b0001 << lane;
    e.b = 8'hA0 | 8'(lane);
    exp_a.push_back(e);
    for (int k = 0; k < n; k++) begin
      lbuf[lane][ltail[lane]] = {(lastf && (k == n - 1)), bytes[k]};
      ltail[lane]++;
      e.b = bytes[k];
      exp_a.push_back(e);
    end
  endtask

  // dut_a requester driver: present lane heads, advance on observed transfers.
  initial begin : drv_a
    logic [N-1:0] xfer;
    for (int i = 0; i < N; i++) begin
      lhead[i] = 0;
      ltail[i] = 0;
      xcnt[i]  = 0;
    end
    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_a.req_last  = '0;
    forever begin
      @(negedge clk);
      xfer = bus_a.req_valid & bus_a.req_ready;
      if ((bus_a.req_ready & ~bus_a.grant) != '0) bad_ready++;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (xfer[i] && (lhead[i] != ltail[i])) begin
          lhead[i]++;
          xcnt[i]++;
        end
        if (lhead[i] != ltail[i]) begin
          bus_a.req_valid[i]        = 1'b1;
          bus_a.req_data[8*i +: 8]  = lbuf[i][lhead[i]][7:0];
          bus_a.req_last[i]         = lbuf[i][lhead[i]][8];
        end else begin
          bus_a.req_valid[i] = 1'b0;
          bus_a.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // dut_b requester driver, lane 0 only.
  initial begin : drv_b
    logic xfer;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.req_last  = '0;
    forever begin
      @(negedge clk);
      xfer = bus_b.req_valid[0] & bus_b.req_ready[0];
      @(posedge clk);
      #2;
      if (xfer && (lhead_b != ltail_b)) lhead_b++;
      if (lhead_b != ltail_b) begin
        bus_b.req_valid[0]   = 1'b1;
        bus_b.req_data[7:0]  = lbuf_b[lhead_b][7:0];
        bus_b.req_last[0]    = lbuf_b[lhead_b][8];
      end else begin
        bus_b.req_valid[0] = 1'b0;
        bus_b.req_last[0]  = 1'b0;
      end
    end
  end

  // UART model + monitor for dut_a: FRAME cycles of ena_tx, then tx_done.
  int frames_a = 0;
  int done_edge_a = 0;
  int tcount = 0;
  initial begin : uart_a
    int   fcnt;
    exp_t e;
    fcnt = 0;
    bus_a.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_a.timeout_err) tcount++;
      if (bus_a.tx_done) chk("a_ena_after_done", 32'(bus_a.ena_tx), 32'd0);
      bus_a.tx_done = 1'b0;
      if (bus_a.ena_tx) begin
        fcnt++;
        if (fcnt == FRAME) begin
          fcnt = 0;
          bus_a.tx_done = 1'b1;
          done_edge_a = cyc + 1;
          frames_a++;
          if (exp_a.size() == 0) begin
            chk("a_unexpected_frame", 32'(bus_a.data_send), 32'hFFFF_FFFF);
          end else begin
            e = exp_a.pop_front();
            chk("a_line_byte", 32'(bus_a.data_send), 32'(e.b));
            chk("a_line_grant", 32'(bus_a.grant), 32'(e.g));
          end
        end
      end else begin
        fcnt = 0;
      end
    end
  end

  // UART model + monitor for dut_b, also measuring the inter-frame gap.
  int frames_b = 0;
  initial begin : uart_b
    int   fcnt;
    int   lowcnt;
    logic prev;
    fcnt   = 0;
    lowcnt = 0;
    prev   = 1'b0;
    bus_b.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_b.tx_done = 1'b0;
      if (bus_b.ena_tx && !prev && frames_b > 0) chk("b_gap", lowcnt, 1);
      lowcnt = bus_b.ena_tx ? 0 : lowcnt + 1;
      prev   = bus_b.ena_tx;
      if (bus_b.ena_tx) begin
        fcnt++;
        if (fcnt == FRAME) begin
          fcnt = 0;
          bus_b.tx_done = 1'b1;
          frames_b++;
          if (exp_b.size() == 0) begin
            chk("b_unexpected_frame", 32'(bus_b.data_send), 32'hFFFF_FFFF);
          end else begin
            chk("b_line_byte", 32'(bus_b.data_send), 32'(exp_b.pop_front()));
          end
        end
      end else begin
        fcnt = 0;
      end
    end
  end

  task automatic wait_a(input string name, input int maxc);
    int k;
    k = 0;
    while ((exp_a.size() != 0 || bus_a.busy) && k < maxc) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk({name, "_drained"}, 32'((exp_a.size() == 0) && !bus_a.busy), 32'd1);
  endtask

  initial begin : stim
    int         k;
    int         start;
    logic [7:0] bvec [10];
    bvec = '{8'h3A, 8'hC5, 8'h01, 8'hFE, 8'h7E, 8'h80, 8'h00, 8'hFF, 8'h5A, 8'hA5};
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_grant",     32'(bus_a.grant),       32'd0);
    chk("rst_owner",     32'(bus_a.owner_id),    32'd0);
    chk("rst_busy",      32'(bus_a.busy),        32'd0);
    chk("rst_timeout",   32'(bus_a.timeout_err), 32'd0);
    chk("rst_ena",       32'(bus_a.ena_tx),      32'd0);
    chk("rst_data",      32'(bus_a.data_send),   32'd0);
    chk("rst_ready",     32'(bus_a.req_ready),   32'd0);
    chk("rst_b_busy",    32'(bus_b.busy),        32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #3;

    // Round robin from ptr=0, requester 0 queues a second packet.
    push_pkt(0, 3, 1'b1, 8'h10, 8'h11, 8'h12);
    push_pkt(1, 3, 1'b1, 8'h20, 8'h21, 8'h22);
    push_pkt(2, 3, 1'b1, 8'h30, 8'h31, 8'h32);
    push_pkt(3, 3, 1'b1, 8'h40, 8'h41, 8'h42);
    push_pkt(0, 3, 1'b1, 8'h50, 8'h51, 8'h52);
    wait_a("rr", 800);

    // Tagged single packet from requester 2.
    xcnt[2] = 0;
    push_pkt(2, 2, 1'b1, 8'h55, 8'h3C, 8'h00);
    wait_a("tag1", 200);
    chk("tag1_ready_pulses", xcnt[2], 2);
    chk("tag1_busy_low",     32'(bus_a.busy),  32'd0);
    chk("tag1_grant_clear",  32'(bus_a.grant), 32'd0);

    // No preemption: requester 0 arrives while 3 owns the line.
    start = frames_a;
    push_pkt(3, 3, 1'b1, 8'h61, 8'h62, 8'h63);
    k = 0;
    while (frames_a < start + 2 && k < 200) begin
      @(posedge clk);
      #3;
      k++;
    end
    push_pkt(0, 1, 1'b1, 8'h0F, 8'h00, 8'h00);
    k = 0;
    while (!bus_a.grant[0] && k < 200) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("np_grant0",     32'(bus_a.grant), 32'h1);
    chk("np_grant_edge", cyc, done_edge_a + 1);
    wait_a("np", 200);

    // Watchdog: owner 1 sends a non-last byte, then goes quiet.
    push_pkt(1, 1, 1'b0, 8'h77, 8'h00, 8'h00);
    k = 0;
    while (exp_a.size() != 0 && k < 200) begin
      @(posedge clk);
      #3;
      k++;
    end
    k = 0;
    while (!bus_a.timeout_err && k < 100) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("wd_pulse",   32'(bus_a.timeout_err), 32'd1);
    chk("wd_latency", cyc - done_edge_a, 16);
    @(posedge clk);
    #3;
    chk("wd_single",  32'(bus_a.timeout_err), 32'd0);
    chk("wd_grant",   32'(bus_a.grant),       32'd0);
    chk("wd_owner",   32'(bus_a.owner_id),    32'd0);
    chk("wd_busy",    32'(bus_a.busy),        32'd0);
    push_pkt(3, 1, 1'b1, 8'h83, 8'h00, 8'h00);
    push_pkt(0, 1, 1'b1, 8'h80, 8'h00, 8'h00);
    wait_a("wd_next", 200);

    // Untagged back-to-back on dut_b.
    for (int i = 0; i < 10; i++) begin
      lbuf_b[ltail_b] = {(i == 9), bvec[i]};
      ltail_b++;
      exp_b.push_back(bvec[i]);
    end
    k = 0;
    while ((exp_b.size() != 0 || bus_b.busy) && k < 400) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("b_frames",  frames_b, 10);
    chk("b_drained", exp_b.size(), 0);

    // Reset in the middle of a data frame.
    start = xcnt[2];
    push_pkt(2, 2, 1'b1, 8'h21, 8'h22, 8'h00);
    k = 0;
    while (xcnt[2] < start + 1 && k < 200) begin
      @(posedge clk);
      #3;
      k++;
    end
    @(negedge clk);
    chk("rm_in_send", 32'(bus_a.ena_tx), 32'd1);
    nrst = 1'b0;
    #1;
    chk("rm_grant",   32'(bus_a.grant),       32'd0);
    chk("rm_owner",   32'(bus_a.owner_id),    32'd0);
    chk("rm_busy",    32'(bus_a.busy),        32'd0);
    chk("rm_timeout", 32'(bus_a.timeout_err), 32'd0);
    chk("rm_ena",     32'(bus_a.ena_tx),      32'd0);
    chk("rm_data",    32'(bus_a.data_send),   32'd0);
    chk("rm_ready",   32'(bus_a.req_ready),   32'd0);
    for (int i = 0; i < N; i++) lhead[i] = ltail[i];
    exp_a.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    chk("rm_idle_busy", 32'(bus_a.busy), 32'd0);
    // ptr back at 0, so requester 0 beats requester 3.
    push_pkt(0, 1, 1'b1, 8'h90, 8'h00, 8'h00);
    push_pkt(3, 1, 1'b1, 8'h93, 8'h00, 8'h00);
    wait_a("post_rst", 200);

    chk("no_foreign_ready", bad_ready, 0);
    chk("timeout_count",    tcount,    1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
